// File: rtl/guia_resp_checker.sv
// On-chip response checker for two-input Guia gate tests: compares each applied
// (a, b) vector's response s against TRUTH, tracks coverage and errors, reports a verdict.
module guia_resp_checker #(
  parameter logic [3:0] TRUTH       = 4'b1001,
  parameter int         ERR_W       = 4,
  parameter int         MAX_SAMPLES = 16,
  parameter int         CNT_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             s,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       coverage,
  output logic             first_fail_valid,
  output logic [1:0]       first_fail_idx,
  output logic [CNT_W-1:0] sample_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  logic [1:0]       idx;
  logic             mism;
  logic [3:0]       cov_next;
  logic [CNT_W-1:0] cnt_next;
  logic [ERR_W-1:0] err_next;
  logic             cov_full;
  logic             at_limit;

  // Result of accepting the current sample, evaluated ahead of the edge.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    idx      = {a, b};
    mism     = (s != TRUTH[idx]);
    cov_next = coverage | (4'b0001 << idx);
    cnt_next = sample_count + 1'b1;
    err_next = err_count;
    if (mism && (err_count != '1)) begin
      err_next = err_count + 1'b1;
    end
    cov_full = (cov_next == 4'b1111);
    at_limit = (cnt_next == CNT_W'(MAX_SAMPLES));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      coverage         <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      sample_count     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // A sample arriving with start is dropped; only the run clears happen.
          if (start) begin
            state            <= RUN;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            coverage         <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            sample_count     <= '0;
          end
        end
        RUN: begin
          if (in_valid) begin
            coverage     <= cov_next;
            sample_count <= cnt_next;
            err_count    <= err_next;
            if (mism && !first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_idx   <= idx;
            end
            // Full coverage wins over the sample limit when both land on one edge.
            if (cov_full) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end else if (at_limit) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/guia_resp_checker.md
Name: guia_resp_checker

Overview:
- Hardware response checker: the receiving end of the two-input gate test flow.
- Today a bench drives the (a, b) vectors and prints the gate output. This block takes each applied vector plus the DUT output s and checks s against an expected truth table.
- It tracks vector coverage, counts mismatches, captures the first failing vector and reports a pass/fail verdict.
- It sits beside any Guia two-input gate module as an on-chip, self-checking monitor.

Parameters:
- TRUTH, 4'b1001, expected s for vector index {a,b}. Bit[idx] is the expected output; the default is XNOR.
- ERR_W, 4, width of the mismatch counter (saturating).
- MAX_SAMPLES, 16, samples accepted in RUN before a forced timeout verdict. Must be ≥ 4.
- CNT_W, 5, sample counter width. Must hold MAX_SAMPLES.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin or restart a check run (single-cycle pulse).
- in_valid  input  1  a, b and s are valid this cycle.
- a  input  1  applied stimulus bit a.
- b  input  1  applied stimulus bit b.
- s  input  1  DUT response to (a, b).
- busy  output  1  state == RUN.
- done  output  1  state == DONE; the verdict is stable.
- pass  output  1  verdict; meaningful only while done = 1.
- err_count  output  ERR_W  number of mismatching samples.
- coverage  output  4  bit[idx] set once vector idx = {a,b} has been seen.
- first_fail_valid  output  1  a mismatch has been captured.
- first_fail_idx  output  2  {a,b} of the first mismatch.
- sample_count  output  CNT_W  samples accepted this run.

Behaviour:
- Reset:
  - Reset is synchronous and active-high, and overrides everything, including a run in progress.
  - Reset forces state = IDLE.
  - All outputs go to 0: busy, done, pass, err_count, coverage, first_fail_valid, first_fail_idx, sample_count.
- FSM has three states: IDLE, RUN, DONE.
  - IDLE: start=1 moves to RUN and clears err_count, coverage, first_fail_*, sample_count and pass.
  - RUN: start is ignored.
  - DONE: start=1 moves to RUN with the same clears. Otherwise DONE holds.
  - in_valid is ignored in IDLE and DONE.
  - If start and in_valid are both high in IDLE or DONE, the sample is dropped; only the clears take effect.
- Sample acceptance happens in RUN, on a clock edge with in_valid=1:
  - idx = {a,b}; expected = TRUTH[idx]; mism = (s != expected).
  - coverage[idx] is set to 1. sample_count increments.
  - If mism: err_count increments and saturates at all-ones.
  - If mism and first_fail_valid=0: first_fail_valid=1 and first_fail_idx=idx. The capture is never overwritten within a run.
- Latency:
  - All outputs are registered.
  - The effect of a sample is visible in the cycle after the accepting edge.
  - No combinational path from inputs to outputs.
- Completion:
  - If the accepting edge makes coverage == 4'b1111, the same edge moves the FSM to DONE.
  - pass = (err_count after this sample == 0).
- Timeout:
  - Timeout applies if the accepting edge makes sample_count == MAX_SAMPLES and coverage is still incomplete.
  - The FSM moves to DONE with pass = 0, regardless of errors.
  - If full coverage and the MAX_SAMPLES limit are reached on the same edge, the coverage rule applies: pass depends on errors only.
- Repeated vectors are allowed. They are checked and counted but add no coverage.
- Saturation: once err_count is at all-ones it stays there. pass remains 0.
- In DONE, all result outputs hold their values until start or reset.

Test Plan:
- Reset plus full correct sweep, TRUTH=4'b1001:
  - Stimulus: start, then (a,b,s) = (0,0,1), (0,1,0), (1,0,0), (1,1,1), one per cycle.
  - Required: done=1 one cycle after the 4th sample; pass=1, err_count=0, coverage=1111, sample_count=4.
- Single fault:
  - Stimulus: same sweep but (1,0) returns s=1.
  - Required: done=1, pass=0, err_count=1, first_fail_valid=1, first_fail_idx=2'b10.
- Gapped and repeated vectors:
  - Stimulus: in_valid toggled with idle cycles; (0,0) applied 3 times before the other vectors.
  - Required: sample_count=6, coverage completes on the last new vector, and done is asserted on that edge only.
- Timeout, MAX_SAMPLES=16:
  - Stimulus: only (0,0,1) applied, 16 times.
  - Required: done=1 after sample 16; pass=0, coverage=0001, err_count=0.
- Saturation plus restart:
  - Stimulus: 20 wrong samples with ERR_W=4 and MAX_SAMPLES=24, then start issued in DONE.
  - Required: err_count stays at 15; after start, busy=1 and all counters are 0.
- Mid-run reset:
  - Stimulus: reset=1 after 2 samples.
  - Required: next cycle state IDLE, all outputs 0; start and in_valid pulses during reset have no effect.
